// File: rtl/queue_drain_if.sv
// ============================================================================
//  queue_drain_if
//  Queue-side and output-side signal bundle for queue_drain.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface queue_drain_if #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
);
   logic                  qEmpty_IN;
   logic [DATA_WIDTH-1:0] qData_IN;
   logic                  qPopReq_OUT;
   logic                  qFlush_OUT;
   logic                  flush_IN;
   logic                  outValid_OUT;
   logic [DATA_WIDTH-1:0] outData_OUT;
   logic                  outReady_IN;
   logic                  stall_OUT;
   logic [CNT_WIDTH-1:0]  drainCnt_OUT;

   // Environment view: feeds the queue head and downstream ready.
   modport master (
      output qEmpty_IN, qData_IN, flush_IN, outReady_IN,
      input  qPopReq_OUT, qFlush_OUT, outValid_OUT, outData_OUT,
             stall_OUT, drainCnt_OUT
   );

   modport slave (
      input  qEmpty_IN, qData_IN, flush_IN, outReady_IN,
      output qPopReq_OUT, qFlush_OUT, outValid_OUT, outData_OUT,
             stall_OUT, drainCnt_OUT
   );
endinterface

`default_nettype wire

// File: rtl/queue_drain.sv
// ============================================================================
//  queue_drain
//  Pops DONE entries from the circular queue head into a 2-entry output FIFO.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module queue_drain #(
   parameter int DATA_WIDTH  = 8,
   parameter int DONE_BIT    = 7,
   parameter int STALL_LIMIT = 15,
   parameter int CNT_WIDTH   = 16
) (
   input  logic          clk,
   input  logic          reset,
   queue_drain_if.slave  bus
);

   localparam logic [0:0] ST_RUN        = 1'b0;
   localparam logic [0:0] ST_FLUSH      = 1'b1;
   localparam logic [7:0] C_STALL_LIMIT = 8'(STALL_LIMIT);

   logic [0:0]            state_q, state_d;
   logic [1:0]            bufCnt_q, bufCnt_d;
   logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
   logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
   logic [7:0]            stallCnt_q, stallCnt_d;
   logic                  stall_q, stall_d;
   logic [CNT_WIDTH-1:0]  drainCnt_q, drainCnt_d;

   logic w_run;
   logic w_done;
   logic w_valid;
   logic w_deq;
   logic w_pop;

   assign w_run   = (state_q == ST_RUN);
   assign w_done  = bus.qData_IN[DONE_BIT];
   assign w_valid = (bufCnt_q != 2'd0);
   assign w_deq   = w_valid && bus.outReady_IN && !bus.flush_IN;
   // Reset gates the request so the queue never sees a pop while reset is held.
   assign w_pop   = reset && w_run && !bus.qEmpty_IN && w_done && !bus.flush_IN &&
                    ((bufCnt_q != 2'd2) || w_deq);

   always_comb begin
      state_d    = bus.flush_IN ? ST_FLUSH : ST_RUN;
      bufCnt_d   = bufCnt_q;
      buf0_d     = buf0_q;
      buf1_d     = buf1_q;
      stallCnt_d = stallCnt_q;
      drainCnt_d = drainCnt_q + CNT_WIDTH'(w_pop);

      if (bus.flush_IN) begin
         bufCnt_d = 2'd0;
      end else begin
         // buf0 is always the oldest entry; buf1 only holds data when bufCnt==2.
         case ({w_pop, w_deq})
            2'b10: begin
               if (bufCnt_q == 2'd0) buf0_d = bus.qData_IN;
               else                  buf1_d = bus.qData_IN;
               bufCnt_d = bufCnt_q + 2'd1;
            end
            2'b01: begin
               buf0_d   = buf1_q;
               bufCnt_d = bufCnt_q - 2'd1;
            end
            2'b11: begin
               if (bufCnt_q == 2'd1) begin
                  buf0_d = bus.qData_IN;
               end else begin
                  buf0_d = buf1_q;
                  buf1_d = bus.qData_IN;
               end
            end
            default: ;
         endcase
      end

      if (bus.flush_IN || w_pop || bus.qEmpty_IN) begin
         stallCnt_d = 8'd0;
      end else if (w_run && !w_done && (stallCnt_q < C_STALL_LIMIT)) begin
         stallCnt_d = stallCnt_q + 8'd1;
      end

      stall_d = (stallCnt_d == C_STALL_LIMIT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_RUN;
         bufCnt_q   <= 2'd0;
         buf0_q     <= '0;
         buf1_q     <= '0;
         stallCnt_q <= 8'd0;
         stall_q    <= 1'b0;
         drainCnt_q <= '0;
      end else begin
         state_q    <= state_d;
         bufCnt_q   <= bufCnt_d;
         buf0_q     <= buf0_d;
         buf1_q     <= buf1_d;
         stallCnt_q <= stallCnt_d;
         stall_q    <= stall_d;
         drainCnt_q <= drainCnt_d;
      end
   end

   assign bus.qPopReq_OUT  = w_pop;
   assign bus.qFlush_OUT   = (state_q == ST_FLUSH);
   assign bus.outValid_OUT = w_valid;
   assign bus.outData_OUT  = buf0_q;
   assign bus.stall_OUT    = stall_q;
   assign bus.drainCnt_OUT = drainCnt_q;

endmodule

`default_nettype wire

// File: tb/tb_queue_drain.sv
// ============================================================================
//  tb_queue_drain
//  Directed vector table plus hand sequences for stall, wrap and async reset.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_queue_drain;

   typedef struct packed {
      logic        e;
      logic [7:0]  d;
      logic        f;
      logic        r;
      logic        p;
      logic        v;
      logic [7:0]  od;
      logic        qf;
      logic        st;
      logic [15:0] dc;
   } vec_t;

   logic clk;
   logic reset;
   logic reset2;
   int   n_checks;
   int   n_errors;
   vec_t tv[26];

   queue_drain_if #(.DATA_WIDTH(8), .CNT_WIDTH(16)) bus  ();
   queue_drain_if #(.DATA_WIDTH(8), .CNT_WIDTH(4))  bus2 ();

   queue_drain #(.DATA_WIDTH(8), .DONE_BIT(7), .STALL_LIMIT(15), .CNT_WIDTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   queue_drain #(.DATA_WIDTH(8), .DONE_BIT(7), .STALL_LIMIT(15), .CNT_WIDTH(4)) dut2 (
      .clk   (clk),
      .reset (reset2),
      .bus   (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(logic e, logic [7:0] d, logic f, logic r, logic p, logic v,
                               logic [7:0] od, logic qf, logic st, logic [15:0] dc);
      vec_t x;
      x = '{e: e, d: d, f: f, r: r, p: p, v: v, od: od, qf: qf, st: st, dc: dc};
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic e, input logic [7:0] d, input logic f, input logic r);
      bus.qEmpty_IN   = e;
      bus.qData_IN    = d;
      bus.flush_IN    = f;
      bus.outReady_IN = r;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset    = 1'b0;
      reset2   = 1'b0;
      drive(1'b1, 8'h00, 1'b0, 1'b0);
      bus2.qEmpty_IN   = 1'b0;
      bus2.qData_IN    = 8'h80;
      bus2.flush_IN    = 1'b0;
      bus2.outReady_IN = 1'b1;

      //            e     d      f     r     p     v     od     qf    st    dc
      tv[0]  = mk(1'b0, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0);
      tv[1]  = mk(1'b0, 8'h82, 1'b0, 1'b1, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 16'd1);
      tv[2]  = mk(1'b0, 8'h83, 1'b0, 1'b1, 1'b1, 1'b1, 8'h82, 1'b0, 1'b0, 16'd2);
      tv[3]  = mk(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h83, 1'b0, 1'b0, 16'd3);
      tv[4]  = mk(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd3);
      // Downstream stalled: two pops fill the buffer, then pop+deq at bufCnt=2.
      tv[5]  = mk(1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd3);
      tv[6]  = mk(1'b0, 8'h82, 1'b0, 1'b0, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 16'd4);
      tv[7]  = mk(1'b0, 8'h83, 1'b0, 1'b0, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0, 16'd5);
      tv[8]  = mk(1'b0, 8'h83, 1'b0, 1'b0, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0, 16'd5);
      tv[9]  = mk(1'b0, 8'h83, 1'b0, 1'b1, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 16'd5);
      tv[10] = mk(1'b0, 8'h84, 1'b0, 1'b1, 1'b1, 1'b1, 8'h82, 1'b0, 1'b0, 16'd6);
      tv[11] = mk(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h83, 1'b0, 1'b0, 16'd7);
      tv[12] = mk(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h84, 1'b0, 1'b0, 16'd7);
      tv[13] = mk(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd7);
      // Flush with two buffered and a done head.
      tv[14] = mk(1'b0, 8'h91, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd7);
      tv[15] = mk(1'b0, 8'h92, 1'b0, 1'b0, 1'b1, 1'b1, 8'h91, 1'b0, 1'b0, 16'd8);
      tv[16] = mk(1'b0, 8'h93, 1'b0, 1'b0, 1'b0, 1'b1, 8'h91, 1'b0, 1'b0, 16'd9);
      tv[17] = mk(1'b0, 8'h93, 1'b1, 1'b1, 1'b0, 1'b1, 8'h91, 1'b0, 1'b0, 16'd9);
      tv[18] = mk(1'b0, 8'h93, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'd9);
      tv[19] = mk(1'b0, 8'h93, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd9);
      tv[20] = mk(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h93, 1'b0, 1'b0, 16'd10);
      tv[21] = mk(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd10);
      // Back-to-back flush extends FLUSH by one cycle.
      tv[22] = mk(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd10);
      tv[23] = mk(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'd10);
      tv[24] = mk(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'd10);
      tv[25] = mk(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd10);

      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      #3;
      chk("rst_pop",    32'(bus.qPopReq_OUT),  32'd0);
      chk("rst_valid",  32'(bus.outValid_OUT), 32'd0);
      chk("rst_data",   32'(bus.outData_OUT),  32'd0);
      chk("rst_qflush", 32'(bus.qFlush_OUT),   32'd0);
      chk("rst_stall",  32'(bus.stall_OUT),    32'd0);
      chk("rst_cnt",    32'(bus.drainCnt_OUT), 32'd0);
      step();

      for (int i = 0; i < 26; i++) begin
         drive(tv[i].e, tv[i].d, tv[i].f, tv[i].r);
         #3;
         chk($sformatf("v%0d_pop", i),    32'(bus.qPopReq_OUT),  32'(tv[i].p));
         chk($sformatf("v%0d_valid", i),  32'(bus.outValid_OUT), 32'(tv[i].v));
         if (tv[i].v)
            chk($sformatf("v%0d_data", i), 32'(bus.outData_OUT), 32'(tv[i].od));
         chk($sformatf("v%0d_qflush", i), 32'(bus.qFlush_OUT),   32'(tv[i].qf));
         chk($sformatf("v%0d_stall", i),  32'(bus.stall_OUT),    32'(tv[i].st));
         chk($sformatf("v%0d_cnt", i),    32'(bus.drainCnt_OUT), 32'(tv[i].dc));
         step();
      end

      // Stall alarm: 15 blocked cycles, then a done head pops and clears it.
      for (int j = 1; j <= 15; j++) begin
         drive(1'b0, 8'h05, 1'b0, 1'b1);
         #3;
         chk($sformatf("stall_c%0d", j), 32'(bus.stall_OUT), 32'd0);
         chk($sformatf("stall_pop_c%0d", j), 32'(bus.qPopReq_OUT), 32'd0);
         step();
      end
      drive(1'b0, 8'h85, 1'b0, 1'b1);
      #3;
      chk("stall_c16", 32'(bus.stall_OUT), 32'd1);
      chk("stall_pop_c16", 32'(bus.qPopReq_OUT), 32'd1);
      step();
      drive(1'b1, 8'h00, 1'b0, 1'b1);
      #3;
      chk("stall_c17", 32'(bus.stall_OUT), 32'd0);
      chk("stall_data_c17", 32'(bus.outData_OUT), 32'h85);
      step();

      // Saturation, then clearing by an empty queue.
      for (int j = 1; j <= 20; j++) begin
         drive(1'b0, 8'h05, 1'b0, 1'b1);
         #3;
         chk($sformatf("sat_c%0d", j), 32'(bus.stall_OUT), 32'(j >= 16));
         step();
      end
      drive(1'b1, 8'h00, 1'b0, 1'b1);
      #3;
      chk("sat_empty", 32'(bus.stall_OUT), 32'd1);
      step();
      #3;
      chk("sat_clear", 32'(bus.stall_OUT), 32'd0);
      step();

      // Counter wrap on the 4-bit instance, popping every cycle.
      reset2 = 1'b1;
      repeat (15) step();
      chk("wrap_f", 32'(bus2.drainCnt_OUT), 32'd15);
      step();
      chk("wrap_0", 32'(bus2.drainCnt_OUT), 32'd0);
      step();
      chk("wrap_1", 32'(bus2.drainCnt_OUT), 32'd1);

      // Asynchronous reset while an entry is buffered.
      drive(1'b0, 8'h81, 1'b0, 1'b0);
      #3;
      chk("ar_pop", 32'(bus.qPopReq_OUT), 32'd1);
      step();
      drive(1'b0, 8'h85, 1'b0, 1'b0);
      #3;
      chk("ar_valid_pre", 32'(bus.outValid_OUT), 32'd1);
      chk("ar_data_pre",  32'(bus.outData_OUT),  32'h81);
      #1;
      reset = 1'b0;
      #1;
      chk("ar_valid", 32'(bus.outValid_OUT), 32'd0);
      chk("ar_data",  32'(bus.outData_OUT),  32'd0);
      chk("ar_cnt",   32'(bus.drainCnt_OUT), 32'd0);
      chk("ar_pop_low", 32'(bus.qPopReq_OUT), 32'd0);
      step();
      #3;
      chk("ar_pop_edge", 32'(bus.qPopReq_OUT), 32'd0);
      chk("ar_valid_edge", 32'(bus.outValid_OUT), 32'd0);
      reset = 1'b1;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
